// File: rtl/ad7794_pkg.sv
// Shared types and AD7794 command constants for the single-conversion reader.
package ad7794_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_CFG,
        WR_MODE,
        WAIT_RDY,
        RD_DATA,
        FINISH
    } state_t;

    // Communications-register bytes: write CONFIG, write MODE, read DATA.
    localparam logic [7:0] COMM_WR_CFG  = 8'h10;
    localparam logic [7:0] COMM_WR_MODE = 8'h08;
    localparam logic [7:0] COMM_RD_DATA = 8'h58;

    // Configuration register with the input buffer enabled; gain and channel OR'ed in.
    localparam logic [15:0] CFG_BASE = 16'h0010;

    function automatic logic [15:0] cfg_word(input logic [2:0] gain, input logic [2:0] channel);
        return CFG_BASE | {5'b0, gain, 8'b0} | {13'b0, channel};
    endfunction

endpackage

// File: rtl/ad7794_if.sv
// Serial pins of the AD7794 on the carrier (U18); master = reader, slave = ADC.
interface ad7794_if;
    logic U18_CS;
    logic U18_SCLK;
    logic U18_DIN;
    logic U18_DOUT_RDY;
    logic U18_CLK;

    modport master (
        output U18_CS,
        output U18_SCLK,
        output U18_DIN,
        output U18_CLK,
        input  U18_DOUT_RDY
    );

    modport slave (
        input  U18_CS,
        input  U18_SCLK,
        input  U18_DIN,
        input  U18_CLK,
        output U18_DOUT_RDY
    );
endinterface

// File: rtl/ad7794_shift.sv
// Bit-timed SPI mode-3 shifter: up to 32 bits MSB-first, each bit low half then high half.
module ad7794_shift #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [5:0]  len,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic [31:0] rx_word
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic          half_end;

    assign half_end = (div_cnt == DIV_LAST);

    // miso is already synchronized; sampling at the end of the high half
    // absorbs the two-clock synchronizer lag after the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            sclk    <= 1'b1;
            mosi    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_word <= '0;
        end else if (!busy) begin
            if (load) begin
                busy    <= 1'b1;
                sclk    <= 1'b0;
                mosi    <= tx_word[31];
                tx_sr   <= {tx_word[30:0], 1'b0};
                bit_cnt <= 5'(len - 6'd1);
                div_cnt <= '0;
            end
        end else begin
            div_cnt <= half_end ? '0 : div_cnt + DW'(1);
            if (half_end) begin
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    rx_word <= {rx_word[30:0], miso};
                    if (bit_cnt == 5'd0) begin
                        busy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                        sclk    <= 1'b0;
                        mosi    <= tx_sr[31];
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ad7794_reader.sv
// Single-conversion AD7794 reader: writes CONFIG and MODE, waits for RDY, reads 24-bit data.
// Handshake: start is taken only when busy=0; busy stays high through the done cycle, done pulses once.
module ad7794_reader
    import ad7794_pkg::*;
#(
    parameter int          CLK_DIV   = 16,
    parameter int          TIMEOUT   = 2**20,
    parameter logic [15:0] MODE_WORD = 16'h200A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  channel,
    input  logic [2:0]  gain,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [23:0] data,
    output state_t      state_dbg,
    ad7794_if.master    u18
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [1:0]    rdy_sync;
    logic [TW-1:0] wait_cnt;
    logic [DW-1:0] fin_cnt;
    logic          to_flag;
    logic          cs_q;
    logic          start_ok;

    logic          sh_load;
    logic [5:0]    sh_len;
    logic [31:0]   sh_tx;
    logic          sh_busy;
    logic          sh_sclk;
    logic          sh_mosi;
    logic [31:0]   sh_rx;
    logic          unused_rx;

    assign start_ok  = (state == IDLE) && start && !busy;
    assign state_dbg = state;
    assign unused_rx = ^sh_rx[31:24];

    assign u18.U18_CS   = cs_q;
    assign u18.U18_SCLK = sh_sclk;
    assign u18.U18_DIN  = sh_mosi;
    assign u18.U18_CLK  = 1'b0;

    ad7794_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (sh_load),
        .len     (sh_len),
        .tx_word (sh_tx),
        .miso    (rdy_sync[1]),
        .busy    (sh_busy),
        .sclk    (sh_sclk),
        .mosi    (sh_mosi),
        .rx_word (sh_rx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Each word is loaded on the cycle that enters its state, so the shifter is busy from the first cycle there.
    always_comb begin
        state_n = state;
        sh_load = 1'b0;
        sh_len  = 6'd24;
        sh_tx   = '0;
        case (state)
            IDLE: if (start_ok) begin
                state_n = WR_CFG;
                sh_load = 1'b1;
                sh_tx   = {COMM_WR_CFG, cfg_word(gain, channel), 8'h00};
            end
            WR_CFG: if (!sh_busy) begin
                state_n = WR_MODE;
                sh_load = 1'b1;
                sh_tx   = {COMM_WR_MODE, MODE_WORD, 8'h00};
            end
            WR_MODE: if (!sh_busy) state_n = WAIT_RDY;
            WAIT_RDY: begin
                if (!rdy_sync[1]) begin
                    state_n = RD_DATA;
                    sh_load = 1'b1;
                    sh_len  = 6'd32;
                    sh_tx   = {COMM_RD_DATA, 24'hFF_FFFF};
                end else if (wait_cnt == TO_LAST) begin
                    state_n = FINISH;
                end
            end
            RD_DATA: if (!sh_busy) state_n = FINISH;
            FINISH:  if (fin_cnt == DIV_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_sync <= 2'b11;
            wait_cnt <= '0;
            fin_cnt  <= '0;
            to_flag  <= 1'b0;
            cs_q     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            data     <= '0;
        end else begin
            rdy_sync <= {rdy_sync[0], u18.U18_DOUT_RDY};
            done     <= 1'b0;
            wait_cnt <= (state == WAIT_RDY) ? wait_cnt + TW'(1) : '0;
            fin_cnt  <= (state == FINISH) ? fin_cnt + DW'(1) : '0;
            if (start_ok) begin
                busy    <= 1'b1;
                cs_q    <= 1'b0;
                to_flag <= 1'b0;
            end else if (state == IDLE) begin
                busy <= 1'b0;
            end
            if (state == WAIT_RDY && state_n == FINISH) to_flag <= 1'b1;
            if (state_n == FINISH) cs_q <= 1'b1;
            if (state == FINISH && state_n == IDLE) begin
                done    <= 1'b1;
                timeout <= to_flag;
                if (!to_flag) data <= sh_rx[23:0];
            end
        end
    end

endmodule

// File: tb/tb_ad7794_reader.sv
// Bench for ad7794_reader: behavioural AD7794 on the serial pins, DIN and result scoreboards.
module tb_ad7794_reader;
    import ad7794_pkg::*;

    localparam int          TO_CYC    = 1000;
    localparam int          RDY_DELAY = 500;
    localparam logic [15:0] MODE      = 16'h200A;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
    logic [2:0] channel = 3'd0, gain = 3'd0;
    logic       busy_a, done_a, timeout_a, busy_b, done_b, timeout_b;
    logic [23:0] data_a, data_b;
    state_t     st_a, st_b;

    ad7794_if if_a ();
    ad7794_if if_b ();

    logic adc_rdy = 1'b1;
    assign if_a.U18_DOUT_RDY = adc_rdy;
    assign if_b.U18_DOUT_RDY = adc_rdy;

    ad7794_reader #(.CLK_DIV(4), .TIMEOUT(TO_CYC), .MODE_WORD(MODE)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .channel(channel), .gain(gain),
        .busy(busy_a), .done(done_a), .timeout(timeout_a), .data(data_a),
        .state_dbg(st_a), .u18(if_a)
    );

    ad7794_reader #(.CLK_DIV(2), .TIMEOUT(TO_CYC), .MODE_WORD(MODE)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .channel(channel), .gain(gain),
        .busy(busy_b), .done(done_b), .timeout(timeout_b), .data(data_b),
        .state_dbg(st_b), .u18(if_b)
    );

    // The ADC model and monitors follow whichever DUT is selected.
    logic m_cs, m_sclk, m_din, m_busy, m_done, m_timeout;
    logic [23:0] m_data;
    state_t m_st;
    logic [3:0] cd;
    assign m_cs      = sel ? if_b.U18_CS   : if_a.U18_CS;
    assign m_sclk    = sel ? if_b.U18_SCLK : if_a.U18_SCLK;
    assign m_din     = sel ? if_b.U18_DIN  : if_a.U18_DIN;
    assign m_busy    = sel ? busy_b    : busy_a;
    assign m_done    = sel ? done_b    : done_a;
    assign m_timeout = sel ? timeout_b : timeout_a;
    assign m_data    = sel ? data_b    : data_a;
    assign m_st      = sel ? st_b      : st_a;
    assign cd        = sel ? 4'd2 : 4'd4;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] exp_din_q[$];
    logic [24:0] exp_res_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_cfg(input logic [2:0] ch, input logic [2:0] gn);
        return 16'h0010 | {5'b0, gn, 8'h00} | {13'b0, ch};
    endfunction

    // ---------------- AD7794 model ----------------
    int nrise = 0, half_cnt = 0, rdy_timer = 0, cyc = 0;
    int din_viol = 0, lo_viol = 0, hi_viol = 0;
    logic skip_hi = 1'b1, prev_sclk = 1'b1, prev_din = 1'b1, rdy_mode = 1'b1;
    logic [23:0] sr = '0, rd_word = '0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= m_sclk;
        prev_din  <= m_din;
        if (m_cs) begin
            nrise     <= 0;
            half_cnt  <= 0;
            skip_hi   <= 1'b1;
            rdy_timer <= 0;
            adc_rdy   <= 1'b1;
        end else begin
            half_cnt <= (m_sclk != prev_sclk) ? 1 : half_cnt + 1;
            if (m_sclk && (m_din != prev_din)) din_viol <= din_viol + 1;
            if (m_sclk && !prev_sclk) begin
                if (half_cnt != int'(cd)) lo_viol <= lo_viol + 1;
                sr    <= {sr[22:0], m_din};
                nrise <= nrise + 1;
                if (nrise == 23 || nrise == 47 || nrise == 55) begin
                    if (exp_din_q.size() == 0) begin
                        check("din_word_pending", 32'(exp_din_q.size() != 0), 1);
                    end else begin
                        check("din_word", (nrise == 55) ? {16'h0, sr[6:0], m_din} : {sr[22:0], m_din},
                              exp_din_q[0]);
                        exp_din_q.delete(0);
                    end
                end
                if (nrise == 47 && rdy_mode) rdy_timer <= RDY_DELAY;
            end
            if (!m_sclk && prev_sclk) begin
                if (!skip_hi && half_cnt < int'(cd)) hi_viol <= hi_viol + 1;
                skip_hi <= 1'b0;
                if (nrise >= 56 && nrise < 80) adc_rdy <= rd_word[79 - nrise];
            end
            if (rdy_timer == 1) adc_rdy <= 1'b0;
            if (rdy_timer != 0) rdy_timer <= rdy_timer - 1;
        end
    end

    // ---------------- result monitor ----------------
    int done_cnt = 0, t_wait = 0, t_done = 0;
    state_t st_prev = IDLE;

    always @(negedge clk) begin
        st_prev <= m_st;
        if (m_st == WAIT_RDY && st_prev != WAIT_RDY) t_wait <= cyc;
        if (m_done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
            if (exp_res_q.size() == 0) begin
                check("result_pending", 32'(exp_res_q.size() != 0), 1);
            end else begin
                check("done_data", m_data, exp_res_q[0][23:0]);
                check("done_timeout", m_timeout, exp_res_q[0][24]);
                exp_res_q.delete(0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_txn(input logic [2:0] ch, input logic [2:0] gn, input logic rd,
                            input logic [23:0] exp_data);
        exp_din_q.push_back({8'h10, exp_cfg(ch, gn)});
        exp_din_q.push_back({8'h08, MODE});
        if (rd) exp_din_q.push_back(24'h000058);
        exp_res_q.push_back({~rd, exp_data});
    endtask

    task automatic pulse_start(input logic which);
        @(posedge clk); #1;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("accept_busy", m_busy, 1);
        check("accept_cs_low", m_cs, 0);
    endtask

    task automatic wait_done(input int budget);
        int  c0;
        bit  seen;
        c0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #1;
            if (done_cnt != c0) seen = 1'b1;
        end
        check("done_within_budget", 32'(seen), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c1, d0;
        bit hit;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs", if_a.U18_CS, 1);
        check("rst_sclk", if_a.U18_SCLK, 1);
        check("rst_din", if_a.U18_DIN, 1);
        check("rst_clk_pin", if_a.U18_CLK, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_data", data_a, 0);
        check("rst_state", 32'(st_a), 32'(IDLE));
        @(posedge clk); #1 rst_n = 1'b1;

        // Nominal conversion, channel 3, gain 0.
        rdy_mode = 1'b1;
        rd_word  = 24'hABCDEF;
        channel  = 3'd3;
        gain     = 3'd0;
        push_txn(3'd3, 3'd0, 1'b1, 24'hABCDEF);
        pulse_start(1'b0);
        wait_done(5000);

        // RDY never asserted: timeout after TIMEOUT clocks plus the CS-high gap.
        rdy_mode = 1'b0;
        channel  = 3'd5;
        gain     = 3'd7;
        push_txn(3'd5, 3'd7, 1'b0, 24'hABCDEF);
        pulse_start(1'b0);
        wait_done(5000);
        check("timeout_latency", 32'(t_done - t_wait), 32'(TO_CYC + 4));
        check("data_held", m_data, 24'hABCDEF);

        // Start pulses while busy, then one on the done cycle: all ignored.
        rdy_mode = 1'b1;
        rd_word  = 24'($urandom_range(0, 24'hFF_FFFF));
        channel  = 3'($urandom_range(0, 7));
        gain     = 3'($urandom_range(0, 7));
        push_txn(channel, gain, 1'b1, rd_word);
        pulse_start(1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(20, 150)) @(posedge clk);
            #1 start_a = 1'b1;
            channel = 3'($urandom_range(0, 7));
            gain    = 3'($urandom_range(0, 7));
            @(posedge clk); #1 start_a = 1'b0;
        end
        wait_done(5000);
        c1 = done_cnt;
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("done_cycle_start_busy", m_busy, 0);
        check("done_cycle_start_cs", m_cs, 1);
        repeat (400) @(negedge clk);
        #1 check("single_done", 32'(done_cnt), 32'(c1));

        // Reset during RD_DATA aborts without a done pulse.
        rd_word = 24'h123456;
        channel = 3'd2;
        gain    = 3'd4;
        exp_din_q.push_back({8'h10, exp_cfg(3'd2, 3'd4)});
        exp_din_q.push_back({8'h08, MODE});
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk); #1;
            if (m_st == RD_DATA) hit = 1'b1;
        end
        check("reach_rd_data", 32'(hit), 1);
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_cs_high", m_cs, 1);
        check("abort_sclk_high", m_sclk, 1);
        check("abort_busy", m_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_data_cleared", m_data, 0);
        check("abort_din_q_empty", exp_din_q.size(), 0);

        // Normal transaction after the abort.
        rd_word = 24'h5A5A5A;
        channel = 3'd6;
        gain    = 3'd1;
        push_txn(3'd6, 3'd1, 1'b1, 24'h5A5A5A);
        pulse_start(1'b0);
        wait_done(5000);

        // Fastest SCLK, single set LSB.
        sel     = 1'b1;
        rd_word = 24'h000001;
        channel = 3'd1;
        gain    = 3'd2;
        push_txn(3'd1, 3'd2, 1'b1, 24'h000001);
        pulse_start(1'b1);
        wait_done(5000);
        repeat (20) @(negedge clk);
        #1;

        check("din_stable_high", 32'(din_viol), 0);
        check("sclk_low_width", 32'(lo_viol), 0);
        check("sclk_high_width", 32'(hi_viol), 0);
        check("din_q_drained", exp_din_q.size(), 0);
        check("res_q_drained", exp_res_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad7794_reader.md
AD7794_READER -- requirements
Module: ad7794_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: system clocks per SCLK half-period, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 2**20: maximum clocks spent waiting for conversion ready.
REQ-003 SHALL have parameter MODE_WORD, default 16'h200A: AD7794 mode register value (single conversion).
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request; ignored unless busy=0.
REQ-008 channel  input  3  AD7794 channel select, latched at accepted start.
REQ-009 gain  input  3  PGA gain code, latched at accepted start.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 timeout  output  1  valid with done; 1 = ready never seen.
REQ-013 data  output  24  last conversion result; held until next done.
REQ-014 U18_CS  output  1  chip select, active low.
REQ-015 U18_SCLK  output  1  serial clock, idles high (SPI mode 3).
REQ-016 U18_DIN  output  1  serial data to ADC.
REQ-017 U18_DOUT_RDY  input  1  serial data / ready from ADC, asynchronous.
REQ-018 U18_CLK  output  1  external clock pin, constant 0 (internal oscillator).

Function
REQ-019 SHALL pass U18_DOUT_RDY through a 2-flop synchronizer before any use.
REQ-020 FSM states SHALL be IDLE, WR_CFG, WR_MODE, WAIT_RDY, RD_DATA, FINISH.
REQ-021 IDLE->WR_CFG on start with busy=0; U18_CS falls the same edge busy rises.
REQ-022 WR_CFG SHALL shift 24 bits MSB-first: 8'h10, then config {2'b00, gain, 8'h10 pattern bits per pkg, channel} as defined in package constant CFG_BASE OR'ed with gain<<8 and channel.
REQ-023 WR_MODE SHALL shift 24 bits: 8'h08 then MODE_WORD.
REQ-024 DIN SHALL change on SCLK falling edge; input SHALL be sampled at SCLK rising edge (synchronized value, 2-clock lag compensated by sampling at end of high half-period).
REQ-025 Each bit SHALL take exactly 2*CLK_DIV clocks; SCLK high between bytes, no gaps.
REQ-026 WAIT_RDY SHALL keep CS low, SCLK high, count clocks; exit to RD_DATA when synchronized DOUT_RDY=0.
REQ-027 If count reaches TIMEOUT in WAIT_RDY, go FINISH with timeout=1; data unchanged.
REQ-028 RD_DATA SHALL shift out 8'h58 then 24 read clocks with DIN=1, capturing 24 bits MSB-first.
REQ-029 FINISH SHALL raise CS for CLK_DIV clocks, then pulse done, update data (if timeout=0), clear busy, return IDLE.
REQ-030 start while busy=1 SHALL be ignored with no effect.
REQ-031 done and new start on same cycle: start is ignored (busy still 1 that cycle).

Reset
REQ-032 On rst_n low, immediately: state IDLE, U18_CS=1, U18_SCLK=1, U18_DIN=1, busy=0, done=0, timeout=0, data=0, counters 0.
REQ-033 Reset mid-transaction SHALL abort with no done pulse; CS returns high asynchronously.

Structure
REQ-034 Package ad7794_pkg SHALL hold state enum, COMM_WR_CFG=8'h10, COMM_WR_MODE=8'h08, COMM_RD_DATA=8'h58, CFG_BASE.
REQ-035 One sub-module ad7794_shift SHALL implement the bit-timed 32-bit shifter (load, length, busy, rx word).
REQ-036 Top-level SHALL connect to the carrier modport U18 signals directly.

Verification
REQ-037 Bench model of AD7794: start, channel=3, gain=0, CLK_DIV=4 -> DIN sequence 0x10, cfg, 0x08, 0x200A; ready after 500 clks; read 0xABCDEF -> data=0xABCDEF, timeout=0, one done.
REQ-038 TIMEOUT=1000, RDY held high -> done at WAIT_RDY entry+1000(+CS gap), timeout=1, data keeps prior 0xABCDEF.
REQ-039 start pulses during busy -> exactly one transaction, one done.
REQ-040 rst_n low during RD_DATA -> CS=1 same cycle, no done; next start completes normally.
REQ-041 Check every SCLK half-period = CLK_DIV clocks and DIN stable across each rising edge; CLK_DIV=2 result 0x000001 read correctly.
